// File: rtl/muldiv_seq_pkg.sv
// Shared constants for the iterative RV32M multiply/divide sequencer:
// funct3 encodings, FSM state encodings and operand-signedness helpers.
package muldiv_seq_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [2:0] {
    MDS_IDLE = 3'd0,
    MDS_MUL  = 3'd1,
    MDS_DIV  = 3'd2,
    MDS_FIX  = 3'd3,
    MDS_DONE = 3'd4
  } mds_state_e;

  function automatic logic rs1_signed(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned magnitude loop: add-then-shift-right for multiply,
// shift-left-then-trial-subtract (restoring) for divide.
module muldiv_step
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] trial;

  always_comb begin
    // Multiply: acc = {partial product high, remaining multiplier bits}
    sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    // Divide: acc = {rem, quo}; the shifted remainder needs XLEN+1 bits
    trial = acc[2*XLEN-1:XLEN-1] - {1'b0, operand};
    if (is_div) begin
      if (!trial[XLEN]) acc_next = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else              acc_next = {acc[2*XLEN-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: magnitudes are looped XLEN times in
// muldiv_step, then the sign is applied and the requested word selected in FIX.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output mds_state_e      state_o
);

  // Handshake: an op is accepted on a rising edge where start_i=1, flush_i=0 and
  // busy_o=0; busy_o stays high until the cycle after the single done_o pulse,
  // and result_o is valid while done_o=1 (it then holds until the next result).
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN-1);

  mds_state_e        state_q, state_d;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [2*XLEN-1:0] acc_q, acc_step, prod_s;
  logic [XLEN-1:0]   opnd_q, result_q;
  logic [CNT_W-1:0]  cnt_q;

  logic            s1, s2, neg_in, div_zero, div_ovf, fast, accept;
  logic [XLEN-1:0] mag1, mag2, fast_res, fix_res;

  always_comb begin
    s1       = rs1_signed(op_i);
    s2       = rs2_signed(op_i);
    mag1     = (s1 && rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
    mag2     = (s2 && rs2_i[XLEN-1]) ? -rs2_i : rs2_i;
    // Remainder takes the dividend's sign; everything else is the xor of the signs
    neg_in   = (s1 & rs1_i[XLEN-1]) ^ (is_rem(op_i) ? 1'b0 : (s2 & rs2_i[XLEN-1]));
    div_zero = op_i[2] && (rs2_i == '0);
    div_ovf  = ((op_i == MD_DIV) || (op_i == MD_REM)) && (rs1_i == MIN_INT) &&
               (rs2_i == ALL_ONES);
    fast     = div_zero || div_ovf;
    if (div_zero) fast_res = op_i[1] ? rs1_i : ALL_ONES;
    else          fast_res = op_i[1] ? '0 : MIN_INT;
    accept   = (state_q == MDS_IDLE) && start_i && !flush_i;
  end

  always_comb begin
    prod_s = neg_q ? -acc_q : acc_q;
    case (op_q)
      MD_MUL:                     fix_res = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:            fix_res = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      default:                    fix_res = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    endcase
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div   (state_q == MDS_DIV),
    .acc      (acc_q),
    .operand  (opnd_q),
    .acc_next (acc_step)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= MDS_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MDS_IDLE: if (accept) state_d = fast ? MDS_DONE : (op_i[2] ? MDS_DIV : MDS_MUL);
      MDS_MUL,
      MDS_DIV:  if (cnt_q == CNT_LAST) state_d = MDS_FIX;
      MDS_FIX:  state_d = MDS_DONE;
      MDS_DONE: state_d = MDS_IDLE;
      default:  state_d = MDS_IDLE;
    endcase
    if (flush_i && (state_q != MDS_IDLE)) state_d = MDS_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        MDS_IDLE: if (accept) begin
          op_q   <= op_i;
          neg_q  <= neg_in;
          cnt_q  <= '0;
          acc_q  <= op_i[2] ? {{XLEN{1'b0}}, mag1} : {{XLEN{1'b0}}, mag2};
          opnd_q <= op_i[2] ? mag2 : mag1;
          if (fast) result_q <= fast_res;
        end
        MDS_MUL, MDS_DIV: begin
          acc_q <= acc_step;
          if (cnt_q != CNT_LAST) cnt_q <= cnt_q + 1'b1;
        end
        MDS_FIX: if (!flush_i) result_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign busy_o   = (state_q != MDS_IDLE);
  assign done_o   = (state_q == MDS_DONE);
  assign result_o = result_q;
  assign state_o  = state_q;

endmodule
